// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and widths for the data-memory arbiter between IF and the MEM stage.
package mem_arbiter_pkg;

  localparam int ADDRESS_LEN = 32;
  localparam int WORD_LEN    = 32;
  localparam int WAIT_W      = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  localparam logic ARB_OWNER_IF  = 1'b0;
  localparam logic ARB_OWNER_MEM = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between the IF and MEM requesters.
// A tie goes to the port that was not granted last.
module arb_pick (
  input  logic if_req_i,
  input  logic mem_req_i,
  input  logic last_grant_i,
  output logic any_o,
  output logic owner_o
);

  assign any_o = if_req_i | mem_req_i;
  // Holding last_grant_i at IF turns the tie rule into fixed MEM-over-IF priority.
  assign owner_o = (if_req_i && mem_req_i) ? ~last_grant_i : mem_req_i;

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port data memory between instruction fetch and the MEM stage.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise MEM always beats IF.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [ADDRESS_LEN-1:0] if_adr,
  output logic [WORD_LEN-1:0]    if_rdata,
  output logic                   if_ack,
  input  logic                   mem_req,
  input  logic                   mem_we,
  input  logic [ADDRESS_LEN-1:0] mem_adr,
  input  logic [WORD_LEN-1:0]    mem_wdata,
  output logic [WORD_LEN-1:0]    mem_rdata,
  output logic                   mem_ack,
  output logic [ADDRESS_LEN-1:0] m_adr,
  output logic [WORD_LEN-1:0]    m_write_data,
  output logic                   m_mem_read,
  output logic                   m_mem_write,
  input  logic [WORD_LEN-1:0]    m_out,
  output logic                   busy
);

  arb_state_e             state_q, state_d;
  logic [WAIT_W-1:0]      cnt_q, cnt_d;
  logic                   owner_q, owner_d;
  logic                   we_q, we_d;
  logic [ADDRESS_LEN-1:0] adr_q, adr_d;
  logic [WORD_LEN-1:0]    wdata_q, wdata_d;
  logic [WORD_LEN-1:0]    if_rdata_q, if_rdata_d;
  logic [WORD_LEN-1:0]    mem_rdata_q, mem_rdata_d;
  logic                   last_grant;
  logic                   pick_any;
  logic                   pick_owner;

  arb_pick u_pick (
    .if_req_i     (if_req),
    .mem_req_i    (mem_req),
    .last_grant_i (last_grant),
    .any_o        (pick_any),
    .owner_o      (pick_owner)
  );

`ifdef MEM_ARB_RR_EN
  logic last_grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= ARB_OWNER_IF;
    end else if (state_q == ARB_IDLE && pick_any) begin
      last_grant_q <= pick_owner;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = ARB_OWNER_IF;
`endif

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no branch leaves one unassigned and infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    we_d        = we_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_ACCESS;
          cnt_d   = WAIT_W'(WAIT_CYCLES);
          owner_d = pick_owner;
          if (pick_owner == ARB_OWNER_MEM) begin
            we_d    = mem_we;
            adr_d   = mem_adr;
            wdata_d = mem_wdata;
          end else begin
            we_d    = 1'b0;
            adr_d   = if_adr;
            wdata_d = '0;
          end
        end
      end
      ARB_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ARB_DONE;
          if (!we_q) begin
            if (owner_q == ARB_OWNER_MEM) mem_rdata_d = m_out;
            else                          if_rdata_d  = m_out;
          end
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      cnt_q       <= '0;
      owner_q     <= ARB_OWNER_IF;
      we_q        <= 1'b0;
      adr_q       <= '0;
      wdata_q     <= '0;
      // NOTE: the read-data holding registers are cleared too, since reset must zero every output.
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Strobes decode from registered state only, so reset drops them without waiting for an edge.
  assign m_adr        = adr_q;
  assign m_write_data = wdata_q;
  assign m_mem_read   = (state_q == ARB_ACCESS) && !we_q;
  assign m_mem_write  = (state_q == ARB_ACCESS) && we_q && (cnt_q == '0);
  assign if_ack       = (state_q == ARB_DONE) && (owner_q == ARB_OWNER_IF);
  assign mem_ack      = (state_q == ARB_DONE) && (owner_q == ARB_OWNER_MEM);
  assign if_rdata     = if_rdata_q;
  assign mem_rdata    = mem_rdata_q;
  assign busy         = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with WAIT_CYCLES=2 and one with WAIT_CYCLES=0,
// each backed by a small behavioural memory with combinational read and edge-triggered write.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A, WAIT_CYCLES = 2
  logic        if_req, if_ack, mem_req, mem_we, mem_ack, m_mem_read, m_mem_write, busy;
  logic [31:0] if_adr, if_rdata, mem_adr, mem_wdata, mem_rdata, m_adr, m_write_data, m_out;
  // Instance B, WAIT_CYCLES = 0
  logic        b_if_req, b_if_ack, b_mem_ack, b_m_mem_read, b_m_mem_write, b_busy;
  logic [31:0] b_if_adr, b_if_rdata, b_mem_rdata, b_m_adr, b_m_write_data, b_m_out;

  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];

  always @(posedge clk) if (m_mem_write) mem_a[m_adr[9:0]] <= m_write_data;
  always @(posedge clk) if (b_m_mem_write) mem_b[b_m_adr[9:0]] <= b_m_write_data;
  assign m_out   = mem_a[m_adr[9:0]];
  assign b_m_out = mem_b[b_m_adr[9:0]];

  mem_arbiter #(.WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_adr(if_adr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .m_adr(m_adr), .m_write_data(m_write_data), .m_mem_read(m_mem_read),
    .m_mem_write(m_mem_write), .m_out(m_out), .busy(busy)
  );

  mem_arbiter #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_adr(b_if_adr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .mem_req(1'b0), .mem_we(1'b0), .mem_adr(32'd0), .mem_wdata(32'd0),
    .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack),
    .m_adr(b_m_adr), .m_write_data(b_m_write_data), .m_mem_read(b_m_mem_read),
    .m_mem_write(b_m_mem_write), .m_out(b_m_out), .busy(b_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Steps falling edges on instance A until the selected ack is seen or the budget runs out.
  task automatic wait_ack(input bit is_mem, input int budget, output bit got, output int cycles,
                          output int rd, output int wr, output int wr_at, output int other);
    got = 1'b0; cycles = 0; rd = 0; wr = 0; wr_at = 0; other = 0;
    while (!got && cycles < budget) begin
      @(negedge clk);
      cycles++;
      rd = rd + int'(m_mem_read);
      if (m_mem_write) begin
        wr++;
        wr_at = cycles;
      end
      if (is_mem ? if_ack : mem_ack) other++;
      if (is_mem ? mem_ack : if_ack) got = 1'b1;
    end
  endtask

  bit got;
  int cyc, rd, wr, wr_at, other;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[250] = 32'd10;  mem_a[251] = 32'd20; mem_a[1000] = 32'd7; mem_a[600] = 32'd55;
    mem_b[252] = 32'd200; mem_b[253] = 32'd201;

    rst = 1'b1;
    if_req = 0; if_adr = 0; mem_req = 0; mem_we = 0; mem_adr = 0; mem_wdata = 0;
    b_if_req = 0; b_if_adr = 0;
    repeat (2) @(negedge clk);
    check("reset_strobes", 32'({if_ack, mem_ack, m_mem_read, m_mem_write, busy}), 32'd0);
    check("reset_data", if_rdata | mem_rdata | m_adr | m_write_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: MEM read of 250
    mem_req = 1; mem_we = 0; mem_adr = 32'd250;
    wait_ack(1'b1, 12, got, cyc, rd, wr, wr_at, other);
    check("rd_ack_seen", 32'(got), 32'd1);
    check("rd_latency", 32'(cyc), 32'd4);
    check("rd_read_cycles", 32'(rd), 32'd3);
    check("rd_no_write", 32'(wr), 32'd0);
    check("rd_data", mem_rdata, 32'd10);
    check("rd_if_ack_quiet", 32'(other), 32'd0);
    mem_req = 0;
    @(negedge clk);
    check("rd_ack_pulse", 32'({mem_ack, busy}), 32'd0);
    check("rd_data_hold", mem_rdata, 32'd10);

    // 2: MEM write 99 to 503, then back-to-back read of 503
    mem_req = 1; mem_we = 1; mem_adr = 32'd503; mem_wdata = 32'd99;
    wait_ack(1'b1, 12, got, cyc, rd, wr, wr_at, other);
    check("wr_latency", 32'(cyc), 32'd4);
    check("wr_strobe_count", 32'(wr), 32'd1);
    check("wr_strobe_last_cycle", 32'(wr_at), 32'd3);
    check("wr_no_read", 32'(rd), 32'd0);
    check("wr_mem_word", mem_a[503], 32'd99);
    mem_we = 0;
    wait_ack(1'b1, 12, got, cyc, rd, wr, wr_at, other);
    check("wr_readback_spacing", 32'(cyc), 32'd5);
    check("wr_readback_data", mem_rdata, 32'd99);
    mem_req = 0;
    @(negedge clk);

    // 4: reset during a write with cnt==1
    mem_req = 1; mem_we = 1; mem_adr = 32'd600; mem_wdata = 32'd77;
    @(negedge clk);
    @(negedge clk);
    check("rstw_pre_no_write", 32'(m_mem_write), 32'd0);
    check("rstw_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    mem_req = 0; mem_we = 0;
    #1;
    check("rstw_strobes", 32'({if_ack, mem_ack, m_mem_read, m_mem_write, busy}), 32'd0);
    check("rstw_data", if_rdata | mem_rdata | m_adr | m_write_data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rstw_word_unchanged", mem_a[600], 32'd55);

    // 3: simultaneous IF 1000 / MEM 251; MEM then presents a second read of 250
    if_req = 1; if_adr = 32'd1000;
    mem_req = 1; mem_we = 0; mem_adr = 32'd251;
    wait_ack(1'b1, 12, got, cyc, rd, wr, wr_at, other);
    check("cont_mem_first_latency", 32'(cyc), 32'd4);
    check("cont_mem_first_data", mem_rdata, 32'd20);
    check("cont_if_waits", 32'(other), 32'd0);
    mem_adr = 32'd250;
`ifdef MEM_ARB_RR_EN
    wait_ack(1'b0, 12, got, cyc, rd, wr, wr_at, other);
    check("cont_rr_if_next", 32'(cyc), 32'd5);
    check("cont_rr_if_data", if_rdata, 32'd7);
    if_req = 0;
    wait_ack(1'b1, 12, got, cyc, rd, wr, wr_at, other);
    check("cont_rr_mem_last", 32'(cyc), 32'd5);
    check("cont_rr_mem_data", mem_rdata, 32'd10);
    mem_req = 0;
`else
    wait_ack(1'b1, 12, got, cyc, rd, wr, wr_at, other);
    check("cont_fix_mem_again", 32'(cyc), 32'd5);
    check("cont_fix_mem_data", mem_rdata, 32'd10);
    mem_req = 0;
    wait_ack(1'b0, 12, got, cyc, rd, wr, wr_at, other);
    check("cont_fix_if_last", 32'(cyc), 32'd5);
    check("cont_fix_if_data", if_rdata, 32'd7);
    if_req = 0;
`endif
    @(negedge clk);

    // 6: address changes after the grant are ignored
    mem_req = 1; mem_we = 0; mem_adr = 32'd251;
    @(negedge clk);
    check("late_adr_latched", m_adr, 32'd251);
    mem_adr = 32'd250;
    @(negedge clk);
    check("late_adr_no_passthru", m_adr, 32'd251);
    wait_ack(1'b1, 12, got, cyc, rd, wr, wr_at, other);
    check("late_adr_latency", 32'(cyc), 32'd2);
    check("late_adr_data", mem_rdata, 32'd20);
    mem_req = 0;
    @(negedge clk);

    // 5: WAIT_CYCLES=0 instance, back-to-back IF reads
    b_if_req = 1; b_if_adr = 32'd252;
    @(negedge clk);
    check("w0_access", 32'({b_m_mem_read, b_busy, b_if_ack}), 32'b110);
    @(negedge clk);
    check("w0_ack", 32'({b_if_ack, b_m_mem_read, b_mem_ack}), 32'b100);
    check("w0_data", b_if_rdata, 32'd200);
    b_if_adr = 32'd253;
    @(negedge clk);
    check("w0_idle_gap", 32'({b_if_ack, b_busy}), 32'd0);
    @(negedge clk);
    check("w0_second_access", 32'(b_m_mem_read), 32'd1);
    @(negedge clk);
    check("w0_second_ack", 32'(b_if_ack), 32'd1);
    check("w0_second_data", b_if_rdata, 32'd201);
    b_if_req = 0;
    @(negedge clk);
    check("w0_ack_pulse", 32'(b_if_ack), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
